offset_ext_arbiter: RTL and testbench
=====================================

Name: offset_ext_arbiter

Overview:
- Shared address-offset unit for the MiniRISC core.
- Accepts requests from two clients: requester 0 is the branch unit and requester 1 is the load/store address generator.
- Each request carries a 32-bit base and a 22-bit signed offset. The block sign-extends the offset to 32 bits, optionally scales it by 4, adds it to the base, and returns the sum through a one-entry registered output.
- A round-robin arbiter decides which requester uses the single extender/adder each cycle.

Parameters:
- OFF_W, 22, width of the signed offset field.
- DATA_W, 32, width of base, extended offset and result.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_base  input  DATA_W  requester 0 base address.
- req0_off  input  OFF_W  requester 0 signed offset.
- req0_scale  input  1  1 = shift the extended offset left by 2 before the add.
- req1_valid  input  1  requester 1 has a request.
- req1_ready  output  1  requester 1 request accepted this cycle.
- req1_base  input  DATA_W  requester 1 base address.
- req1_off  input  OFF_W  requester 1 signed offset.
- req1_scale  input  1  requester 1 scale select.
- res_valid  output  1  result register holds valid data.
- res_ready  input  1  consumer accepts the result.
- res_data  output  DATA_W  base + extended offset.
- res_id  output  1  index of the requester that produced res_data.
- busy  output  1  res_valid OR any reqN_valid.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - res_valid=0, res_data=0, res_id=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - reqN_ready=0 while rst is high.
  - A reset mid-transfer discards the held result; no request is accepted in the reset cycle.
- Free slot:
  - free = !res_valid OR (res_valid AND res_ready).
  - Pass-through in the drain cycle, so a new result can load while the old one drains: one request per cycle sustained throughput.
- Arbitration (combinational, evaluated only when free=1):
  - Only one requester valid: grant it.
  - Both valid: grant the requester != last.
  - free=0: no grant.
- reqN_ready is the grant, combinational from valid, res_valid, res_ready and last. A request is consumed when reqN_valid AND reqN_ready.
- Datapath on a grant:
  - ext = {{(DATA_W-OFF_W){off[OFF_W-1]}}, off}.
  - If scale=1, ext = ext << 2, i.e. {ext[DATA_W-3:0],2'b00}; the top 2 bits are discarded.
  - sum = base + ext, modulo 2^DATA_W; carry is dropped, with no overflow flag.
- Registering on the rising edge after a grant:
  - res_data=sum, res_id=granted index, res_valid=1, last=granted index.
- Latency is 1 cycle from acceptance to res_valid.
- Without a grant:
  - If res_valid AND res_ready, res_valid goes to 0.
  - Otherwise res_valid, res_data, res_id and last hold.
- While res_valid=1 and res_ready=0, res_data and res_id are stable; inputs are not sampled.
- Requesters hold base/off/scale stable while valid and not ready. The block does not check this.
- last changes only on a grant, so one idle requester does not disturb fairness.

Test Plan:
- Reset values: assert rst mid-cycle with res_valid=1 -> res_valid=0, res_data=0, res_id=0 and req0_ready=0 immediately, without a clock edge.
- Negative extension: req0 base=0x00001000, off=22'h3FFFFC, scale=0 -> next cycle res_data=0x00000FFC, res_id=0. Same request with scale=1 -> res_data=0x00000FF0.
- Positive extension and wrap: req1 base=0xFFFFFFF0, off=22'h1FFFFF, scale=0 -> res_data=0x001FFFEF, res_id=1. Base 0xFFFFFFFF, off=1 -> res_data=0x00000000.
- Round-robin: both valid for 4 cycles with res_ready=1, bases 0x100/0x200, off=0 -> grants 0,1,0,1 and res_id sequence 0,1,0,1, one result per cycle.
- Backpressure: hold res_ready=0 with both valid -> after the first grant both reqN_ready=0 and res_data stays stable for 5 cycles. Release res_ready -> the other requester is granted in the same cycle and res_valid stays 1 continuously.
- Idle requester: only req1 valid for 3 consecutive requests -> granted every cycle, last=1. Then both valid -> req0 granted.

Source files
------------

// File: rtl/offset_ext_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : offset_ext_arbiter_if
// Description : Bundle of the two request channels and the result channel of
//               the shared offset extender/adder.
//               slave  modport - the offset unit itself
//               master modport - the requesters plus the result consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface offset_ext_arbiter_if #(
    parameter int OFF_W  = 22,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_base;
    logic [OFF_W-1:0]  req0_off;
    logic              req0_scale;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_base;
    logic [OFF_W-1:0]  req1_off;
    logic              req1_scale;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_id;
    logic              busy;

    modport slave (
        input  req0_valid, req0_base, req0_off, req0_scale,
        input  req1_valid, req1_base, req1_off, req1_scale,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, busy
    );

    modport master (
        output req0_valid, req0_base, req0_off, req0_scale,
        output req1_valid, req1_base, req1_off, req1_scale,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/offset_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : offset_ext_arbiter
// Description : Shared address-offset unit. Two requesters (0 = branch unit,
//               1 = load/store AGU) compete round-robin for one sign-extender
//               and adder. The granted request's offset is sign-extended,
//               optionally scaled by 4, added to its base and stored in a
//               one-entry result register (1-cycle latency, full throughput).
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - slave side of offset_ext_arbiter_if (request channels
//                      0/1, result channel, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module offset_ext_arbiter #(
    parameter int OFF_W  = 22,
    parameter int DATA_W = 32
) (
    input  wire                  clk,
    input  wire                  rst,
    offset_ext_arbiter_if.slave  bus
);
    localparam int c_EXT_W = DATA_W - OFF_W;

    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_id;
    logic              r_last;

    logic              w_free;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_gnt_any;
    logic [DATA_W-1:0] w_base;
    logic [OFF_W-1:0]  w_off;
    logic              w_scale;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_ext_sc;
    logic [DATA_W-1:0] w_sum;

    // The slot is free when empty or when the held result drains this cycle,
    // which lets a new result load behind the departing one.
    assign w_free = !r_res_valid || bus.res_ready;

    // Round-robin: a lone requester always wins; on a tie the one that was
    // not granted last wins. Grants are suppressed while reset is asserted.
    assign w_gnt0 = !rst && w_free && bus.req0_valid && (!bus.req1_valid ||  r_last);
    assign w_gnt1 = !rst && w_free && bus.req1_valid && (!bus.req0_valid || !r_last);
    assign w_gnt_any = w_gnt0 || w_gnt1;

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;

    // Operand select follows the grant; when nothing is granted the sum is
    // unused, so requester 0 is a don't-care default.
    assign w_base  = w_gnt1 ? bus.req1_base  : bus.req0_base;
    assign w_off   = w_gnt1 ? bus.req1_off   : bus.req0_off;
    assign w_scale = w_gnt1 ? bus.req1_scale : bus.req0_scale;

    assign w_ext    = {{c_EXT_W{w_off[OFF_W-1]}}, w_off};
    // Scaling by 4 drops the top two bits; the add wraps modulo 2^DATA_W.
    assign w_ext_sc = w_scale ? {w_ext[DATA_W-3:0], 2'b00} : w_ext;
    assign w_sum    = w_base + w_ext_sc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
            r_last      <= 1'b1;   // requester 0 wins the first tie
        end else if (w_gnt_any) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_sum;
            r_res_id    <= w_gnt1;
            r_last      <= w_gnt1;
        end else if (r_res_valid && bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_id    = r_res_id;
    assign bus.busy      = r_res_valid || bus.req0_valid || bus.req1_valid;
endmodule
`default_nettype wire

// File: tb/tb_offset_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_offset_ext_arbiter
// Description : Self-checking bench for offset_ext_arbiter. Accepted requests
//               push their expected {id,data} into a queue; results leaving
//               the DUT pop and compare. Table vectors cover the extension and
//               wrap cases, hand sequences cover arbitration, backpressure
//               and mid-transfer reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_offset_ext_arbiter;
    localparam int OFF_W  = 22;
    localparam int DATA_W = 32;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] base;
        logic [OFF_W-1:0]  off;
        logic              scale;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [DATA_W:0] exp0 = '0;   // {id, data} expected for requester 0
    logic [DATA_W:0] exp1 = '0;
    logic [DATA_W:0] q[$];
    vec_t            vecs[6];

    offset_ext_arbiter_if #(.OFF_W(OFF_W), .DATA_W(DATA_W)) bus ();

    offset_ext_arbiter #(.OFF_W(OFF_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: sample at the falling edge, pop departing results
    // before pushing newly accepted requests.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.res_valid && bus.res_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(bus.res_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [DATA_W:0] e;
                    e = q.pop_front();
                    chk("res_data", 64'(bus.res_data), 64'(e[DATA_W-1:0]));
                    chk("res_id",   64'(bus.res_id),   64'(e[DATA_W]));
                end
            end
            if (bus.req0_valid && bus.req0_ready) q.push_back(exp0);
            if (bus.req1_valid && bus.req1_ready) q.push_back(exp1);
        end
    end

    task automatic send1(input logic id, input logic [DATA_W-1:0] b,
                         input logic [OFF_W-1:0] o, input logic s,
                         input logic [DATA_W-1:0] e);
        bit acc = 0;
        if (id) begin
            bus.req1_base = b; bus.req1_off = o; bus.req1_scale = s;
            exp1 = {1'b1, e}; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_base = b; bus.req0_off = o; bus.req0_scale = s;
            exp0 = {1'b0, e}; bus.req0_valid = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                acc = 1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1000, 22'h3FFFFC, 1'b0, 32'h0000_0FFC};
        vecs[1] = '{1'b0, 32'h0000_1000, 22'h3FFFFC, 1'b1, 32'h0000_0FF0};
        vecs[2] = '{1'b1, 32'hFFFF_FFF0, 22'h1FFFFF, 1'b0, 32'h001F_FFEF};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 22'h000001, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h0000_0000, 22'h200000, 1'b1, 32'hFF80_0000};
        vecs[5] = '{1'b1, 32'h1234_5678, 22'h000010, 1'b1, 32'h1234_56B8};

        bus.req0_valid = 0; bus.req0_base = 0; bus.req0_off = 0; bus.req0_scale = 0;
        bus.req1_valid = 0; bus.req1_base = 0; bus.req1_off = 0; bus.req1_scale = 0;
        bus.res_ready  = 1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data",  64'(bus.res_data),  64'd0);
        chk("rst_res_id",    64'(bus.res_id),    64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Extension / scaling / wrap vectors
        for (int i = 0; i < 6; i++)
            send1(vecs[i].id, vecs[i].base, vecs[i].off, vecs[i].scale, vecs[i].exp_data);
        idle(2);

        // Round-robin with both requesters valid; last grant was requester 1
        bus.req0_base = 32'h100; bus.req0_off = 0; bus.req0_scale = 0;
        bus.req1_base = 32'h200; bus.req1_off = 0; bus.req1_scale = 0;
        exp0 = {1'b0, 32'h100}; exp1 = {1'b1, 32'h200};
        bus.req0_valid = 1; bus.req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_gnt0", 64'(bus.req0_ready), 64'(k % 2 == 0));
            chk("rr_gnt1", 64'(bus.req1_ready), 64'(k % 2 == 1));
            chk("rr_busy", 64'(bus.busy), 64'd1);
            if (k > 0) chk("rr_res_valid", 64'(bus.res_valid), 64'd1);
            @(posedge clk); #1;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        idle(2);

        // Backpressure: first grant to requester 0, then everything stalls
        bus.res_ready = 0;
        bus.req0_valid = 1; bus.req1_valid = 1;
        @(negedge clk);
        chk("bp_gnt0", 64'(bus.req0_ready), 64'd1);
        chk("bp_gnt1", 64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_rdy0", 64'(bus.req0_ready), 64'd0);
            chk("bp_hold_rdy1", 64'(bus.req1_ready), 64'd0);
            chk("bp_hold_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_hold_data", 64'(bus.res_data), 64'h100);
            chk("bp_hold_id",   64'(bus.res_id),   64'd0);
            @(posedge clk); #1;
        end
        bus.res_ready = 1;
        @(negedge clk);
        chk("bp_release_gnt1", 64'(bus.req1_ready), 64'd1);
        chk("bp_release_valid", 64'(bus.res_valid), 64'd1);
        @(posedge clk); #1;
        bus.req1_valid = 0;
        @(negedge clk);
        chk("bp_cont_valid", 64'(bus.res_valid), 64'd1);
        chk("bp_cont_id",    64'(bus.res_id),    64'd1);
        idle(2);

        // Idle requester 0: requester 1 wins three times in a row
        bus.req1_off = 22'h3FFFFF; bus.req1_scale = 1; bus.req1_valid = 1;
        for (int k = 0; k < 3; k++) begin
            bus.req1_base = 32'h300 + 32'(4 * k);
            exp1 = {1'b1, 32'h2FC + 32'(4 * k)};
            @(negedge clk);
            chk("idle_gnt1", 64'(bus.req1_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus.req0_base = 32'h400; bus.req0_off = 22'h1; bus.req0_scale = 0;
        exp0 = {1'b0, 32'h401};
        bus.req1_base = 32'h30C; exp1 = {1'b1, 32'h308};
        bus.req0_valid = 1;
        @(negedge clk);
        chk("idle_tie_gnt0", 64'(bus.req0_ready), 64'd1);
        chk("idle_tie_gnt1", 64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        @(negedge clk);
        chk("idle_next_gnt1", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1;
        bus.req1_valid = 0;
        idle(2);

        // Reset while a result is held
        bus.res_ready = 0;
        send1(1'b0, 32'h500, 22'h0, 1'b0, 32'h500);
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus.res_valid), 64'd1);
        #1 bus.req0_valid = 1;
        #1 rst = 1;
        #1;
        chk("mid_rst_valid", 64'(bus.res_valid), 64'd0);
        chk("mid_rst_data",  64'(bus.res_data),  64'd0);
        chk("mid_rst_id",    64'(bus.res_id),    64'd0);
        chk("mid_rst_rdy0",  64'(bus.req0_ready), 64'd0);
        q.delete();
        bus.req0_valid = 0;
        bus.res_ready = 1;
        @(posedge clk); #1;
        rst = 0;

        // First tie after reset goes to requester 0
        bus.req0_base = 32'h600; bus.req0_off = 0; bus.req0_scale = 0; exp0 = {1'b0, 32'h600};
        bus.req1_base = 32'h700; bus.req1_off = 0; bus.req1_scale = 0; exp1 = {1'b1, 32'h700};
        bus.req0_valid = 1; bus.req1_valid = 1;
        @(negedge clk);
        chk("post_rst_gnt0", 64'(bus.req0_ready), 64'd1);
        chk("post_rst_gnt1", 64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        @(negedge clk);
        chk("post_rst_next_gnt1", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1;
        bus.req1_valid = 0;
        idle(3);
        @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        chk("final_idle_busy",  64'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
